inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-006 in_kind  input  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ANDI, 7 ORI, 8 XORI, 9 LUI, 10 ADDI, 11 LW, 12 SW, 13 BEQ, 14 J, 15 illegal.
REQ-007 in_rs, in_rt, in_rd  input  5 each  register fields.
REQ-008 in_imm  input  16  immediate/offset field.
REQ-009 in_target  input  26  jump target field.
REQ-010 out_valid  output  1  encoded word available at FIFO head.
REQ-011 out_ready  input  1  consumer takes word when out_valid && out_ready.
REQ-012 out_inst  output  32  MIPS instruction word at FIFO head.
REQ-013 err_illegal  output  1  one-cycle pulse: illegal kind accepted.
REQ-014 inst_count  output  16  count of words pushed into FIFO since reset.

Function
REQ-015 R-type (kinds 1-5) SHALL encode {6'b000000, rs, rt, rd, 5'b00000, funct}; funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
REQ-016 I-type SHALL encode {op, rs, rt, imm}; op ANDI 001100, ORI 001101, XORI 001110, ADDI 001000, LW 100011, SW 101011, BEQ 000100.
REQ-017 LUI SHALL encode {001111, 5'b00000, rt, imm} (rs ignored).
REQ-018 J SHALL encode {000010, target}; NOP SHALL encode 32'h00000000.
REQ-019 Encoding combinational from inputs; accepted word written to FIFO tail on the accepting edge.
REQ-020 in_ready = (occupancy < DEPTH); no full-FIFO bypass: push while full impossible even if out_ready high.
REQ-021 out_valid = (occupancy != 0); out_inst = head entry, stable while out_valid && !out_ready.
REQ-022 Latency: word accepted at edge N is visible on out_inst/out_valid after edge N if FIFO was empty (one cycle).
REQ-023 Simultaneous push and pop (non-full, non-empty): occupancy unchanged, both pointers advance.
REQ-024 Pop and push with FIFO empty: only push occurs (out_valid low, pop ignored).
REQ-025 Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH, width log2(DEPTH)+1.
REQ-026 Illegal kind (15) SHALL be consumed (in_ready honoured), not written to FIFO; err_illegal high the following cycle for exactly one cycle.
REQ-027 Back-to-back illegal requests SHALL hold err_illegal high one cycle per request.
REQ-028 inst_count increments by 1 per legal push, wraps 16'hFFFF -> 0; illegal requests do not count.
REQ-029 FIFO order strictly preserved; out_inst never changes except on pop or empty->non-empty.

Reset
REQ-030 resetn low SHALL immediately clear occupancy, pointers, inst_count, err_illegal; out_valid 0, in_ready 1, out_inst 0.
REQ-031 Reset mid-operation discards all FIFO contents; an in-flight handshake in the reset cycle is dropped.
REQ-032 Deassertion takes effect on the first rising clk edge after resetn high; no request accepted while resetn low.

Verification
REQ-033 ADDI rs=1 rt=2 imm=16'h0005, out_ready=1 -> out_inst 32'h20220005 next cycle, inst_count 1.
REQ-034 ADD rs=1 rt=2 rd=3; SW rs=29 rt=8 imm=4; J target=26'h0000010 -> 32'h00221820, 32'hAFA80004, 32'h08000010 in order.
REQ-035 out_ready=0, push 5 legal requests -> 4 accepted, in_ready 0 on 5th, out_valid 1; then drain -> 4 words in order, out_valid 0.
REQ-036 in_kind=15 -> no push, err_illegal single pulse next cycle, inst_count unchanged.
REQ-037 FIFO holding 2 words, push+pop every cycle for 10 cycles -> occupancy stays 2, pointers wrap, order intact.
REQ-038 Assert resetn low with 3 words queued -> out_valid 0 asynchronously, inst_count 0, FIFO empty after release.

Source files
------------

// File: rtl/inst_encoder_if.sv
// Request/response bundle for the MIPS instruction encoder.
// The slave side is the encoder; the master side is the requester and consumer.
interface inst_encoder_if;
  localparam int unsigned KIND_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              in_valid;
  logic              in_ready;
  logic [KIND_W-1:0] in_kind;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [REG_W-1:0]  in_rd;
  logic [IMM_W-1:0]  in_imm;
  logic [TGT_W-1:0]  in_target;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic              err_illegal;
  logic [CNT_W-1:0]  inst_count;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_inst, err_illegal, inst_count
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_inst, err_illegal, inst_count
  );
endinterface

// File: rtl/inst_encoder.sv
// Encodes instruction requests into 32-bit MIPS words and queues them in a
// DEPTH-entry FIFO; illegal kinds are consumed and flagged with a pulse.
module inst_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  inst_encoder_if.slave  bus
);
  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADD  = 4'd1;
  localparam logic [3:0] K_SUB  = 4'd2;
  localparam logic [3:0] K_AND  = 4'd3;
  localparam logic [3:0] K_OR   = 4'd4;
  localparam logic [3:0] K_SLT  = 4'd5;
  localparam logic [3:0] K_ANDI = 4'd6;
  localparam logic [3:0] K_ORI  = 4'd7;
  localparam logic [3:0] K_XORI = 4'd8;
  localparam logic [3:0] K_LUI  = 4'd9;
  localparam logic [3:0] K_ADDI = 4'd10;
  localparam logic [3:0] K_LW   = 4'd11;
  localparam logic [3:0] K_SW   = 4'd12;
  localparam logic [3:0] K_BEQ  = 4'd13;
  localparam logic [3:0] K_J    = 4'd14;
  localparam logic [3:0] K_ILL  = 4'd15;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_occ;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;

  logic [INST_W-1:0] w_word;
  logic              w_not_full;
  logic              w_not_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Field packing per instruction format.
  always_comb begin
    w_word = '0;
    case (bus.in_kind)
      K_NOP:  w_word = '0;
      K_ADD:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
      K_SUB:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
      K_AND:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100100};
      K_OR:   w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100101};
      K_SLT:  w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b101010};
      K_ANDI: w_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      K_ORI:  w_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      K_XORI: w_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
      K_LUI:  w_word = {6'b001111, 5'b00000, bus.in_rt, bus.in_imm};
      K_ADDI: w_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      K_LW:   w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      K_SW:   w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      K_BEQ:  w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      K_J:    w_word = {6'b000010, bus.in_target};
      default: w_word = '0;
    endcase
  end

  assign w_not_full  = (r_occ < CW'(DEPTH));
  assign w_not_empty = (r_occ != '0);
  assign w_accept    = bus.in_valid && w_not_full;
  assign w_push      = w_accept && (bus.in_kind != K_ILL);
  assign w_pop       = w_not_empty && bus.out_ready;

  assign bus.in_ready    = w_not_full;
  assign bus.out_valid   = w_not_empty;
  assign bus.out_inst    = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign bus.err_illegal = r_err;
  assign bus.inst_count  = r_count;

  // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + CW'(1);
        2'b01:   r_occ <= r_occ - CW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Illegal-request pulse and legal-push counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_err <= w_accept && (bus.in_kind == K_ILL);
      if (w_push) r_count <= r_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed checks of inst_encoder against a queue-based
// model that encodes instructions arithmetically from the opcode tables.
module tb_inst_encoder;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  inst_encoder_if bus();

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_q[$];
  int          m_count;
  bit          m_err;

  function automatic logic [31:0] ref_encode(int kind, int rs, int rt, int rd, int imm, int tgt);
    longint unsigned w;
    int funct;
    int op;
    w = 0;
    funct = 0;
    op = 0;
    case (kind)
      1: funct = 32;
      2: funct = 34;
      3: funct = 36;
      4: funct = 37;
      5: funct = 42;
      6: op = 12;
      7: op = 13;
      8: op = 14;
      10: op = 8;
      11: op = 35;
      12: op = 43;
      13: op = 4;
      default: ;
    endcase
    if (kind >= 1 && kind <= 5)
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(funct);
    else if (kind == 9)
      w = 15 * 67108864 + longint'(rt) * 65536 + longint'(imm);
    else if (kind == 14)
      w = 2 * 67108864 + longint'(tgt);
    else if (kind >= 6 && kind <= 13)
      w = longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    return 32'(w);
  endfunction

  function automatic logic [31:0] exp_inst();
    return (m_q.size() != 0) ? m_q[0] : 32'h0;
  endfunction

  task automatic drive(input bit v, input int kind, input int rs, input int rt,
                       input int rd, input int imm, input int tgt);
    bus.in_valid  = v;
    bus.in_kind   = 4'(kind);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
  endtask

  // Advance one clock, updating the model from the driven request/consume.
  task automatic step();
    bit acc;
    bit pop;
    int kind;
    kind = int'(bus.in_kind);
    acc  = bus.in_valid && (m_q.size() < DEPTH);
    pop  = bus.out_ready && (m_q.size() != 0);
    if (pop) void'(m_q.pop_front());
    if (acc && kind != 15) begin
      m_q.push_back(ref_encode(kind, int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                               int'(bus.in_imm), int'(bus.in_target)));
      m_count = (m_count + 1) % 65536;
    end
    m_err = acc && (kind == 15);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    m_q.delete();
    m_count = 0;
    m_err = 1'b0;
    #23;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.out_inst !== 32'h0) $display("FAIL reset_out_inst got %h exp 0", bus.out_inst); else n_pass++;
    n_total++; if (bus.err_illegal !== 1'b0) $display("FAIL reset_err got %0b exp 0", bus.err_illegal); else n_pass++;
    n_total++; if (bus.inst_count !== 16'h0) $display("FAIL reset_count got %0d exp 0", bus.inst_count); else n_pass++;
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h20220005;
    exp_seq[1] = 32'h00221820;
    exp_seq[2] = 32'hAFA80004;
    exp_seq[3] = 32'h08000010;
    bus.out_ready = 1'b1;
    drive(1'b1, 10, 1, 2, 0, 16'h0005, 0);
    step();
    n_total++; if (bus.out_valid !== 1'b1 || bus.out_inst !== exp_seq[0])
      $display("FAIL addi_word got %h/%0b exp %h/1", bus.out_inst, bus.out_valid, exp_seq[0]); else n_pass++;
    n_total++; if (bus.inst_count !== 16'd1) $display("FAIL addi_count got %0d exp 1", bus.inst_count); else n_pass++;
    for (int i = 1; i < 4; i++) begin
      case (i)
        1: drive(1'b1, 1, 1, 2, 3, 0, 0);
        2: drive(1'b1, 12, 29, 8, 0, 4, 0);
        default: drive(1'b1, 14, 0, 0, 0, 0, 26'h0000010);
      endcase
      step();
      n_total++; if (bus.out_inst !== exp_seq[i])
        $display("FAIL directed_seq%0d got %h exp %h", i, bus.out_inst, exp_seq[i]); else n_pass++;
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL directed_drain got %0b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.inst_count !== 16'(m_count)) $display("FAIL directed_count got %0d exp %0d", bus.inst_count, m_count); else n_pass++;
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.in_ready !== (i < DEPTH))
        $display("FAIL full_in_ready%0d got %0b exp %0b", i, bus.in_ready, (i < DEPTH)); else n_pass++;
      drive(1'b1, 6 + i, i, i + 1, 0, 16'h1000 + i, 0);
      step();
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    n_total++; if (m_q.size() != DEPTH || bus.out_valid !== 1'b1)
      $display("FAIL full_occupancy got valid %0b exp 1 (model %0d)", bus.out_valid, m_q.size()); else n_pass++;
    n_total++; if (bus.out_inst !== exp_inst()) $display("FAIL full_hold got %h exp %h", bus.out_inst, exp_inst()); else n_pass++;
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++; if (bus.out_inst !== exp_inst() || bus.out_valid !== 1'b1)
        $display("FAIL drain%0d got %h exp %h", i, bus.out_inst, exp_inst()); else n_pass++;
      step();
    end
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL drain_empty got %0b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.inst_count !== 16'(m_count)) $display("FAIL full_count got %0d exp %0d", bus.inst_count, m_count); else n_pass++;
  endtask

  task automatic test_illegal();
    int cnt0;
    cnt0 = m_count;
    bus.out_ready = 1'b1;
    drive(1'b1, 15, 3, 4, 5, 6, 7);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    n_total++; if (bus.err_illegal !== 1'b1) $display("FAIL ill_pulse got %0b exp 1", bus.err_illegal); else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL ill_nopush got %0b exp 0", bus.out_valid); else n_pass++;
    step();
    n_total++; if (bus.err_illegal !== 1'b0) $display("FAIL ill_single got %0b exp 0", bus.err_illegal); else n_pass++;
    n_total++; if (bus.inst_count !== 16'(cnt0)) $display("FAIL ill_count got %0d exp %0d", bus.inst_count, cnt0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 15, i, i, i, i, i);
      step();
      n_total++; if (bus.err_illegal !== 1'b1) $display("FAIL ill_b2b%0d got %0b exp 1", i, bus.err_illegal); else n_pass++;
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step();
    n_total++; if (bus.err_illegal !== 1'b0) $display("FAIL ill_b2b_end got %0b exp 0", bus.err_illegal); else n_pass++;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 7, i + 10, i + 20, 0, $urandom_range(0, 65535), 0);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, int'($urandom_range(0, 14)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 67108863)));
      step();
      n_total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_inst !== exp_inst())
        $display("FAIL stream%0d got %h v%0b r%0b exp %h v1 r1", i, bus.out_inst, bus.out_valid, bus.in_ready, exp_inst());
      else n_pass++;
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drain got %0b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_random();
    int kind;
    for (int c = 0; c < 300; c++) begin
      kind = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 14));
      drive($urandom_range(0, 9) < 7, kind, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)), int'($urandom_range(0, 67108863)));
      bus.out_ready = ($urandom_range(0, 9) < 5);
      step();
      n_total++; if (bus.out_valid !== (m_q.size() != 0) || bus.out_inst !== exp_inst())
        $display("FAIL rnd_head c%0d got %h v%0b exp %h v%0b", c, bus.out_inst, bus.out_valid, exp_inst(), (m_q.size() != 0));
      else n_pass++;
      n_total++; if (bus.in_ready !== (m_q.size() < DEPTH))
        $display("FAIL rnd_ready c%0d got %0b exp %0b", c, bus.in_ready, (m_q.size() < DEPTH)); else n_pass++;
      n_total++; if (bus.err_illegal !== m_err)
        $display("FAIL rnd_err c%0d got %0b exp %0b", c, bus.err_illegal, m_err); else n_pass++;
      n_total++; if (bus.inst_count !== 16'(m_count))
        $display("FAIL rnd_count c%0d got %0d exp %0d", c, bus.inst_count, m_count); else n_pass++;
    end
  endtask

  task automatic test_midreset();
    bus.out_ready = 1'b0;
    while (m_q.size() < 3) begin
      drive(1'b1, 11, 5, 6, 0, int'($urandom_range(0, 65535)), 0);
      step();
    end
    drive(1'b1, 1, 1, 1, 1, 0, 0);
    bus.out_ready = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    m_q.delete();
    m_count = 0;
    m_err = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_async_valid got %0b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.inst_count !== 16'h0) $display("FAIL mrst_count got %0d exp 0", bus.inst_count); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mrst_no_accept got %0b exp 0", bus.out_valid); else n_pass++;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0)
      $display("FAIL mrst_empty got %h v%0b exp 0 v0", bus.out_inst, bus.out_valid); else n_pass++;
    drive(1'b1, 9, 31, 7, 0, 16'hBEEF, 0);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    n_total++; if (bus.out_inst !== exp_inst() || bus.inst_count !== 16'd1)
      $display("FAIL mrst_after got %h c%0d exp %h c1", bus.out_inst, bus.inst_count, exp_inst()); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_full();
    test_illegal();
    test_stream();
    test_random();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
